// File: rtl/ram_pkg.sv
// Shared types and helpers for the single-port byte-enable RAM.
// Optional feature macro: RAM_SINGLEPORT_BE_FWD_EN (write-to-read forwarding).
package ram_pkg;

    localparam int MAX_DW = 128;
    localparam int MAX_BE = MAX_DW / 8;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_e;

    function automatic logic [MAX_DW-1:0] byte_merge(
        input logic [MAX_DW-1:0] old_w,
        input logic [MAX_DW-1:0] new_w,
        input logic [MAX_BE-1:0] strb
    );
        logic [MAX_DW-1:0] m;
        m = old_w;
        for (int i = 0; i < MAX_BE; i++) begin
            if (strb[i]) m[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/ram_singleport_be_if.sv
// Read/write bus bundle for ram_singleport_be.
// Optional feature macro: RAM_SINGLEPORT_BE_FWD_EN (no effect on this bundle).
interface ram_singleport_be_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                    busy;
    logic                    rden;
    logic [ADDR_WIDTH-1:0]   raddr;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvalid;
    logic                    wren;
    logic [ADDR_WIDTH-1:0]   waddr;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic [DATA_WIDTH-1:0]   wdata;

    modport master (
        output rden, raddr, wren, waddr, wstrb, wdata,
        input  rdata, rvalid, busy
    );

    modport slave (
        input  rden, raddr, wren, waddr, wstrb, wdata,
        output rdata, rvalid, busy
    );
endinterface

// File: rtl/ram_clear_ctrl.sv
// Post-reset clear sweep: walks addresses 0..SIZE-1, one per cycle.
// Optional feature macro: RAM_SINGLEPORT_BE_FWD_EN (no effect here).
module ram_clear_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int SIZE       = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  clr_we,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(SIZE - 1);

    ram_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (cnt_q == LAST) state_d = READY;
                else               cnt_d   = cnt_q + 1'b1;
            end
            READY: begin
                state_d = READY;
            end
            default: state_d = CLEAR;
        endcase
    end

    assign clr_addr = cnt_q;

endmodule

// File: rtl/ram_singleport_be.sv
// Byte-enable RAM with one read and one write port and a post-reset clear.
// Optional feature macro: RAM_SINGLEPORT_BE_FWD_EN (write-first forwarding).
module ram_singleport_be
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int SIZE       = 1024
) (
    input  logic                    CLK,
    input  logic                    RST,
    output logic                    BUSY,
    input  logic                    RDEN,
    input  logic [ADDR_WIDTH-1:0]   RADDR,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic                    RVALID,
    input  logic                    WREN,
    input  logic [ADDR_WIDTH-1:0]   WADDR,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic [DATA_WIDTH-1:0]   WDATA
);

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] SIZE_W = (ADDR_WIDTH + 1)'(SIZE);

    logic [DATA_WIDTH-1:0] mem [SIZE];

    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  clr_we;
    logic                  busy;

    ram_clear_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .SIZE       (SIZE)
    ) u_clr (
        .CLK      (CLK),
        .RST      (RST),
        .clr_addr (clr_addr),
        .clr_we   (clr_we),
        .busy     (busy)
    );

    assign BUSY = busy;

    logic rd_ok, wr_ok;
    assign rd_ok = ({1'b0, RADDR} < SIZE_W);
    assign wr_ok = !busy && WREN && ({1'b0, WADDR} < SIZE_W);

    // Sweep and user writes share one port so the array maps to block RAM.
    logic [ADDR_WIDTH-1:0] wa;
    logic [DATA_WIDTH-1:0] wd;
    logic [NB-1:0]         we;

    always_comb begin
        wa = WADDR;
        wd = WDATA;
        we = '0;
        if (clr_we) begin
            wa = clr_addr;
            wd = '0;
            we = '1;
        end else if (wr_ok) begin
            we = WSTRB;
        end
    end

    always_ff @(posedge CLK) begin
        for (int b = 0; b < NB; b++) begin
            if (we[b]) mem[wa][b*8 +: 8] <= wd[b*8 +: 8];
        end
    end

    logic [DATA_WIDTH-1:0] rd_word;

`ifdef RAM_SINGLEPORT_BE_FWD_EN
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] old_word;

    assign fwd_hit  = wr_ok && (WADDR == RADDR);
    assign old_word = rd_ok ? mem[RADDR] : '0;

    always_comb begin
        rd_word = old_word;
        if (fwd_hit) begin
            rd_word = DATA_WIDTH'(byte_merge(MAX_DW'(old_word),
                                             MAX_DW'(WDATA),
                                             MAX_BE'(WSTRB)));
        end
    end
`else
    assign rd_word = rd_ok ? mem[RADDR] : '0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RVALID <= 1'b0;
            RDATA  <= '0;
        end else if (busy) begin
            RVALID <= 1'b0;
        end else begin
            RVALID <= RDEN;
            if (RDEN) RDATA <= rd_word;
        end
    end

endmodule

// File: tb/tb_ram_singleport_be.sv
// Directed self-checking bench for ram_singleport_be (SIZE=16, 5-bit address).
// Expected same-address read result depends on RAM_SINGLEPORT_BE_FWD_EN.
module tb_ram_singleport_be;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int SIZE = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ram_singleport_be_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_singleport_be #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .SIZE       (SIZE)
    ) dut (
        .CLK    (clk),
        .RST    (rst_n),
        .BUSY   (bus.busy),
        .RDEN   (bus.rden),
        .RADDR  (bus.raddr),
        .RDATA  (bus.rdata),
        .RVALID (bus.rvalid),
        .WREN   (bus.wren),
        .WADDR  (bus.waddr),
        .WSTRB  (bus.wstrb),
        .WDATA  (bus.wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rden  = 1'b0;
        bus.wren  = 1'b0;
        bus.raddr = '0;
        bus.waddr = '0;
        bus.wstrb = '0;
        bus.wdata = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        bus.wren  = 1'b1;
        bus.waddr = a;
        bus.wdata = d;
        bus.wstrb = s;
        step();
        bus.wren  = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        idle();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.rvalid !== 1'b0 || bus.rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state busy=%b rvalid=%b rdata=%h want 1 0 0",
                     bus.busy, bus.rvalid, bus.rdata);
        end
        step();
        rst_n = 1'b1;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n != SIZE) begin
            errors++;
            $display("FAIL sweep_len got %0d want %0d", n, SIZE);
        end
    endtask

    task automatic test_clear_reads();
        for (int a = 0; a < SIZE; a++) begin
            bus.rden  = 1'b1;
            bus.raddr = AW'(a);
            step();
            checks++;
            if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0) begin
                errors++;
                $display("FAIL clear_read[%0d] rvalid=%b rdata=%h want 1 0",
                         a, bus.rvalid, bus.rdata);
            end
        end
        bus.rden = 1'b0;
        step();
        checks++;
        if (bus.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_drop got %b want 0", bus.rvalid);
        end
    endtask

    task automatic test_byte_write();
        do_write(5, 32'hAABBCCDD, 4'b1111);
        do_write(5, 32'h11223344, 4'b0101);
        do_write(5, 32'h99999999, 4'b0000);
        bus.rden  = 1'b1;
        bus.raddr = 5;
        step();
        bus.rden = 1'b0;
        checks++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL byte_merge rvalid=%b rdata=%h want 1 aa22cc44",
                     bus.rvalid, bus.rdata);
        end
        step();
        checks++;
        if (bus.rvalid !== 1'b0 || bus.rdata !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL rdata_hold rvalid=%b rdata=%h want 0 aa22cc44",
                     bus.rvalid, bus.rdata);
        end
    endtask

    task automatic test_same_addr();
        logic [31:0] exp;
`ifdef RAM_SINGLEPORT_BE_FWD_EN
        exp = 32'hFFFF5678;
`else
        exp = 32'hFFFFFFFF;
`endif
        do_write(3, 32'hFFFFFFFF, 4'b1111);
        bus.wren  = 1'b1;
        bus.waddr = 3;
        bus.wdata = 32'h12345678;
        bus.wstrb = 4'b0011;
        bus.rden  = 1'b1;
        bus.raddr = 3;
        step();
        bus.wren = 1'b0;
        checks++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== exp) begin
            errors++;
            $display("FAIL same_addr rdata=%h want %h", bus.rdata, exp);
        end
        step();
        bus.rden = 1'b0;
        checks++;
        if (bus.rdata !== 32'hFFFF5678) begin
            errors++;
            $display("FAIL same_addr_after rdata=%h want ffff5678", bus.rdata);
        end
    endtask

    task automatic test_back_to_back();
        bus.wren  = 1'b1;
        bus.waddr = 6;
        bus.wdata = 32'hCAFEF00D;
        bus.wstrb = 4'b1111;
        bus.rden  = 1'b1;
        bus.raddr = 5;
        step();
        bus.wren = 1'b0;
        checks++;
        if (bus.rdata !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL diff_addr_read rdata=%h want aa22cc44", bus.rdata);
        end
        bus.raddr = 6;
        step();
        bus.rden = 1'b0;
        checks++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL diff_addr_write rdata=%h want cafef00d", bus.rdata);
        end
    endtask

    task automatic test_oob();
        do_write(AW'(SIZE), 32'hDEADBEEF, 4'b1111);
        bus.rden  = 1'b1;
        bus.raddr = AW'(SIZE);
        step();
        checks++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0) begin
            errors++;
            $display("FAIL oob_read rvalid=%b rdata=%h want 1 0",
                     bus.rvalid, bus.rdata);
        end
        bus.raddr = 0;
        step();
        bus.rden = 1'b0;
        checks++;
        if (bus.rdata !== 32'h0) begin
            errors++;
            $display("FAIL oob_alias rdata=%h want 0", bus.rdata);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bus.rden  = 1'b1;
        bus.raddr = 6;
        step();
        bus.rden = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rvalid !== 1'b0 || bus.rdata !== 32'h0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready rvalid=%b rdata=%h busy=%b want 0 0 1",
                     bus.rvalid, bus.rdata, bus.busy);
        end
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 7; c++) step();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bus.rden  = 1'b1;
        bus.raddr = 2;
        bus.wren  = 1'b1;
        bus.waddr = 2;
        bus.wdata = 32'h5A5A5A5A;
        bus.wstrb = 4'b1111;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            step();
            n++;
            checks++;
            if (bus.rvalid !== 1'b0) begin
                errors++;
                $display("FAIL clear_rvalid cycle %0d got %b want 0", n, bus.rvalid);
            end
        end
        idle();
        checks++;
        if (n != SIZE) begin
            errors++;
            $display("FAIL resweep_len got %0d want %0d", n, SIZE);
        end
        bus.rden  = 1'b1;
        bus.raddr = 2;
        step();
        checks++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0) begin
            errors++;
            $display("FAIL clear_ignored_wr rdata=%h want 0", bus.rdata);
        end
        bus.raddr = 5;
        step();
        bus.rden = 1'b0;
        checks++;
        if (bus.rdata !== 32'h0) begin
            errors++;
            $display("FAIL resweep_zero rdata=%h want 0", bus.rdata);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        idle();
        #2;
        test_reset();
        test_clear_reads();
        test_byte_write();
        test_same_addr();
        test_back_to_back();
        test_oob();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_singleport_be.md
RAM_SINGLEPORT_BE -- requirements
Module: ram_singleport_be

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: read/write address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: word width; multiple of 8, range 8..128.
REQ-003 SHALL have parameter SIZE, default 1024: number of words; 2 <= SIZE <= 2**ADDR_WIDTH.
REQ-004 SHALL have port CLK  input  1: single clock, all state on rising edge.
REQ-005 SHALL have port RST  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port BUSY  output  1: high while the post-reset clear sweep runs.
REQ-007 SHALL have port RDEN  input  1: read request.
REQ-008 SHALL have port RADDR  input  ADDR_WIDTH: read address.
REQ-009 SHALL have port RDATA  output  DATA_WIDTH: read data.
REQ-010 SHALL have port RVALID  output  1: RDATA holds the result of the previous cycle's accepted read.
REQ-011 SHALL have port WREN  input  1: write request.
REQ-012 SHALL have port WADDR  input  ADDR_WIDTH: write address.
REQ-013 SHALL have port WSTRB  input  DATA_WIDTH/8: byte enables; bit i covers WDATA[8i+7:8i].
REQ-014 SHALL have port WDATA  input  DATA_WIDTH: write data.

Function
REQ-015 SHALL implement FSM states CLEAR and READY; reset enters CLEAR.
REQ-016 In CLEAR, SHALL write all-zero to one address per cycle, from 0 up to SIZE-1, using an internal counter.
REQ-017 SHALL move CLEAR->READY in the cycle after the write to address SIZE-1, so CLEAR lasts exactly SIZE cycles; READY is terminal until reset.
REQ-018 SHALL drive BUSY=1 in CLEAR and BUSY=0 in READY.
REQ-019 In CLEAR, SHALL ignore RDEN and WREN; no user write reaches the array and RVALID stays 0.
REQ-020 In READY, SHALL accept a read when RDEN=1; RDATA and RVALID update on the next edge (latency 1).
REQ-021 When RDEN=0, SHALL deassert RVALID on the next edge; RDATA SHALL hold its last value.
REQ-022 In READY, with WREN=1, SHALL update only the bytes whose WSTRB bit is 1; WSTRB=0 leaves the word unchanged.
REQ-023 SHALL drop a write with WADDR >= SIZE; a read with RADDR >= SIZE SHALL return all-zero with RVALID=1.
REQ-024 SHALL allow a read and a write in the same cycle to different addresses; the read returns the pre-write contents.
REQ-025 A same-cycle read and write to the same address SHALL behave as specified in Configuration.

Reset
REQ-026 RST low SHALL immediately force: state=CLEAR, clear counter=0, BUSY=1, RVALID=0, RDATA=0.
REQ-027 Array contents SHALL NOT be reset asynchronously; the CLEAR sweep zeroes them.
REQ-028 Reset asserted mid-sweep or mid-operation SHALL restart the sweep from address 0 after release.

Configuration
REQ-029 Macro RAM_SINGLEPORT_BE_FWD_EN SHALL control write-to-read forwarding.
REQ-030 With the macro defined, for a same-cycle same-address read and write, RDATA SHALL be the old word with the WSTRB-enabled bytes replaced by WDATA (write-first, byte-merged).
REQ-031 Without the macro, RDATA SHALL be the old word (read-first); the forwarding registers and comparator SHALL be absent.

Structure
REQ-032 SHALL place the FSM state typedef (CLEAR, READY) and the byte-merge function (old word, new word, strobe -> merged word) in shared package ram_pkg.
REQ-033 SHALL implement the sweep counter and FSM in sub-module ram_clear_ctrl, which outputs clear address, clear write enable and BUSY.
REQ-034 The array SHALL be inferable as block RAM with per-byte write enables; no asynchronous read.

Verification
REQ-035 Reset release, SIZE=16 -> BUSY high for exactly 16 cycles; then every read of addresses 0..15 returns 0 with RVALID=1 one cycle after RDEN.
REQ-036 Write 0xAABBCCDD to address 5 with WSTRB=4'b1111, then write 0x11223344 with WSTRB=4'b0101 -> read of address 5 returns 0xAA22CC44.
REQ-037 Same cycle: write 0x12345678, WSTRB=4'b0011, to address 3 (old value 0xFFFFFFFF), and read address 3 -> RDATA=0xFFFF5678 with FWD_EN, 0xFFFFFFFF without; next read returns 0xFFFF5678 in both builds.
REQ-038 RDEN and WREN pulsed during CLEAR -> no RVALID; write target still reads 0 after READY.
REQ-039 RST asserted at sweep cycle 7 of 16 -> RVALID/RDATA go to 0 immediately; after release BUSY is high for a full 16 cycles.
REQ-040 Read of address SIZE with ADDR_WIDTH>log2(SIZE) -> RDATA=0, RVALID=1; write to address SIZE does not alias address 0.
